// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host port: controller state encoding,
//   frame length and the odd-parity helper used by both the receive checker
//   and the transmit serializer.
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_TX_INHIBIT,
      ST_TX_REQ,
      ST_TX_BITS,
      ST_TX_ACK
   } ps2_state_t;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_BITS = 11;

   // Parity bit that makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Two-flop synchronizer followed by a debounce counter for one PS/2 line.
//   The filtered level only follows the pin after FILTER_CYCLES consecutive
//   samples that disagree with it, so short glitches never reach the FSM.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   line   in   raw (asynchronous) pin level
//   level  out  filtered level, resets to 1 (released bus)
//   fe     out  1-cycle strobe, coincident with level going 1->0
//   re     out  1-cycle strobe, coincident with level going 0->1
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int FILTER_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic level,
   output logic fe,
   output logic re
);

   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         fe    <= 1'b0;
         re    <= 1'b0;
      end else begin
         sync <= {sync[0], line};
         fe   <= 1'b0;
         re   <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            // Enough consecutive disagreeing samples: accept the new level.
            level <= sync[1];
            cnt   <= '0;
            fe    <= ~sync[1];
            re    <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_port.sv
// ---------------------------------------------------------------------------
// ps2_host_port
//   Bidirectional PS/2 host: filtered receiver with frame checking, byte
//   FIFO and error pulses, plus a host->device command transmitter. Both
//   PS/2 lines are open-drain: driven 0 or released, never driven 1.
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   open-drain PS/2 lines
//   rx_data/rx_valid    FIFO head byte / FIFO non-empty
//   rx_ready            pop head when rx_valid & rx_ready
//   rx_err              pulse: bad start/parity/stop or timeout on a frame
//   rx_ovf              pulse: good byte dropped because FIFO was full
//   tx_data/tx_valid    command byte / send request
//   tx_ready            controller idle, request accepted on valid & ready
//   tx_done/tx_err      pulse: device ACK seen / no ACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_port
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_err,
   output logic       rx_ovf,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int TMR_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam logic [3:0] RX_LAST = 4'(PS2_FRAME_BITS - 1);  // stop bit index
   localparam logic [3:0] TX_LAST = 4'(PS2_FRAME_BITS - 2);  // fe that releases data for stop

   // ---------------- line conditioning ----------------
   logic clk_lvl, clk_fe, clk_re;
   logic data_lvl, data_fe, data_re;

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .line  (ps2_clk),
      .level (clk_lvl),
      .fe    (clk_fe),
      .re    (clk_re)
   );

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
      .clk   (clk),
      .rst   (rst),
      .line  (ps2_data),
      .level (data_lvl),
      .fe    (data_fe),
      .re    (data_re)
   );

   logic clk_drive, data_drive;
   assign ps2_clk  = clk_drive  ? 1'b0 : 1'bz;
   assign ps2_data = data_drive ? 1'b0 : 1'bz;

   // ---------------- state and datapath registers ----------------
   ps2_state_t state, state_next;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] timer;
   logic [10:0]   rx_sr;
   logic [8:0]    tx_sr;
   logic          ack_seen;
   logic          ready_q;

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [7:0]    mem [FIFO_DEPTH];

   // ---------------- derived conditions ----------------
   logic        rx_start, wd_active, timeout, any_edge;
   logic [10:0] frame_next;
   logic        frame_good;

   assign rx_start   = clk_fe & ~data_lvl;
   assign any_edge   = clk_fe | clk_re | data_fe | data_re;
   assign wd_active  = state inside {ST_RX, ST_TX_REQ, ST_TX_BITS, ST_TX_ACK};
   assign timeout    = wd_active & (timer == TW'(TIMEOUT_CYCLES - 1));
   assign frame_next = {data_lvl, rx_sr[10:1]};
   assign frame_good = ~frame_next[0] & frame_next[10]
                     & (frame_next[9] == odd_parity(frame_next[8:1]));

   // A device start bit in the same cycle wins over a new TX request.
   assign tx_ready = ready_q & ~rx_start;

   // ---------------- FSM ----------------
   logic rx_shift_en, frame_end, rx_fail;
   logic tx_load, tx_start, tx_bit_en, ack_take, tx_fail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      rx_shift_en = 1'b0;
      frame_end   = 1'b0;
      rx_fail     = 1'b0;
      tx_load     = 1'b0;
      tx_start    = 1'b0;
      tx_bit_en   = 1'b0;
      ack_take    = 1'b0;
      tx_fail     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rx_start) begin
               state_next  = ST_RX;
               rx_shift_en = 1'b1;
            end else if (tx_valid && tx_ready) begin
               state_next = ST_TX_INHIBIT;
               tx_load    = 1'b1;
            end
         end
         ST_RX: begin
            if (timeout) begin
               state_next = ST_IDLE;
               rx_fail    = 1'b1;
            end else if (clk_fe) begin
               rx_shift_en = 1'b1;
               if (bit_cnt == RX_LAST) begin
                  state_next = ST_IDLE;
                  frame_end  = 1'b1;
               end
            end
         end
         ST_TX_INHIBIT: begin
            if (timer == TW'(INHIBIT_CYCLES - 1)) begin
               state_next = ST_TX_REQ;
               tx_start   = 1'b1;
            end
         end
         ST_TX_REQ: begin
            if (timeout) begin
               state_next = ST_IDLE;
               tx_fail    = 1'b1;
            end else if (clk_re) begin
               state_next = ST_TX_BITS;
            end
         end
         ST_TX_BITS: begin
            if (timeout) begin
               state_next = ST_IDLE;
               tx_fail    = 1'b1;
            end else if (clk_fe) begin
               tx_bit_en = 1'b1;
               if (bit_cnt == TX_LAST) state_next = ST_TX_ACK;
            end
         end
         ST_TX_ACK: begin
            if (timeout) begin
               state_next = ST_IDLE;
               tx_fail    = 1'b1;
            end else if (!ack_seen && clk_fe) begin
               ack_take = 1'b1;
            end else if (ack_seen && clk_lvl && data_lvl) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- FIFO control ----------------
   logic pop, full, push_req, push, ovf;

   assign rx_valid = (wr_ptr != rd_ptr);
   assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
   assign pop      = rx_valid & rx_ready;
   assign push_req = frame_end & frame_good;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push     = push_req & (~full | pop);
   assign ovf      = push_req & full & ~pop;
   assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

   // NOTE: the storage array has no reset; rx_data is gated by rx_valid so
   // its power-up contents are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= frame_next[8:1];
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt    <= '0;
         timer      <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         ack_seen   <= 1'b0;
         ready_q    <= 1'b0;
         clk_drive  <= 1'b0;
         data_drive <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_err     <= 1'b0;
         rx_ovf     <= 1'b0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         ready_q <= (state_next == ST_IDLE);

         if (state_next == ST_IDLE)           bit_cnt <= '0;
         else if (rx_shift_en || tx_bit_en)   bit_cnt <= (bit_cnt == RX_LAST) ? bit_cnt : bit_cnt + 4'd1;

         // One timer serves the inhibit delay and the inter-edge watchdog.
         if ((state_next != state) || (state == ST_IDLE) || (wd_active && any_edge))
            timer <= '0;
         else if (timer != TW'(TMR_MAX))
            timer <= timer + 1'b1;

         if (rx_shift_en) rx_sr <= frame_next;

         if (tx_load)        tx_sr <= {odd_parity(tx_data), tx_data};
         else if (tx_bit_en) tx_sr <= {1'b1, tx_sr[8:1]};

         ack_seen <= (state_next == ST_TX_ACK) & (ack_seen | ack_take);

         // Clock is released one cycle after the start bit is driven.
         clk_drive <= (state == ST_TX_INHIBIT);

         if (state_next == ST_IDLE) data_drive <= 1'b0;
         else if (tx_start)         data_drive <= 1'b1;
         else if (tx_bit_en)        data_drive <= ~tx_sr[0];

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         rx_err  <= rx_fail | (frame_end & ~frame_good);
         rx_ovf  <= ovf;
         tx_done <= ack_take & ~data_lvl;
         tx_err  <= tx_fail | (ack_take & data_lvl);
      end
   end

endmodule
